// File: rtl/tile_pingpong_buffer.sv
// N-bank rotating tile buffer between the memory controller (row fill) and the PE array.
// The read side hands out a whole bank (READ_MODE=0) or one row at a time (READ_MODE=1).
module tile_pingpong_buffer #(
  parameter int NUM_BANKS = 2,
  parameter int DEPTH     = 4,
  parameter int ROW_W     = 128,
  parameter int READ_MODE = 0,
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int OW = $clog2(NUM_BANKS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   write_valid,
  output logic                   write_ready,
  input  logic [ROW_W-1:0]       write_data,
  input  logic                   write_last,
  output logic                   read_valid,
  input  logic                   read_ready,
  output logic [DEPTH*ROW_W-1:0] read_data_all,
  output logic [ROW_W-1:0]       read_data,
  output logic                   read_last,
  output logic [CW-1:0]          read_count,
  output logic [OW-1:0]          occupancy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // valid never waits on ready, ready is a pure function of registered state, and
  // a held write row stays on write_data until it is accepted.

  logic [ROW_W-1:0]     r_mem [NUM_BANKS][DEPTH];
  logic [BW-1:0]        r_wr_bank;
  logic [BW-1:0]        r_rd_bank;
  logic [RW-1:0]        r_wr_row;
  logic [RW-1:0]        r_rd_row;
  logic [NUM_BANKS-1:0] r_full;
  logic [CW-1:0]        r_count [NUM_BANKS];

  logic                 w_wr_fire;
  logic                 w_wr_close;
  logic                 w_rd_fire;
  logic                 w_rd_release;
  logic                 w_rd_is_last;
  logic [CW-1:0]        w_head_count;
  logic [NUM_BANKS-1:0] w_full_next;

  function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
    return (b == BW'(NUM_BANKS - 1)) ? '0 : b + BW'(1);
  endfunction

  assign write_ready  = ~r_full[r_wr_bank];
  assign read_valid   = r_full[r_rd_bank];
  assign w_head_count = r_count[r_rd_bank];
  assign w_wr_fire    = write_valid & write_ready;
  assign w_wr_close   = w_wr_fire & ((r_wr_row == RW'(DEPTH - 1)) | write_last);
  assign w_rd_is_last = (CW'(r_rd_row) + CW'(1)) == w_head_count;
  assign w_rd_fire    = read_valid & read_ready;
  // Parallel consumers take the whole bank at once; serial ones free it on the last row.
  assign w_rd_release = w_rd_fire & ((READ_MODE == 0) | w_rd_is_last);

  // The filling bank is never full and the draining bank always is, so the two never collide.
  always_comb begin
    w_full_next = r_full;
    if (w_wr_close)   w_full_next[r_wr_bank] = 1'b1;
    if (w_rd_release) w_full_next[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_bank <= '0;
      r_rd_bank <= '0;
      r_wr_row  <= '0;
      r_rd_row  <= '0;
      r_full    <= '0;
      for (int b = 0; b < NUM_BANKS; b++) r_count[b] <= '0;
    end else if (clear) begin
      r_wr_bank <= '0;
      r_rd_bank <= '0;
      r_wr_row  <= '0;
      r_rd_row  <= '0;
      r_full    <= '0;
      for (int b = 0; b < NUM_BANKS; b++) r_count[b] <= '0;
    end else begin
      r_full <= w_full_next;
      if (w_wr_fire) begin
        if (w_wr_close) begin
          r_count[r_wr_bank] <= CW'(r_wr_row) + CW'(1);
          r_wr_row           <= '0;
          r_wr_bank          <= bank_inc(r_wr_bank);
        end else begin
          r_wr_row <= r_wr_row + RW'(1);
        end
      end
      if (w_rd_fire) begin
        if (w_rd_release) begin
          r_rd_row  <= '0;
          r_rd_bank <= bank_inc(r_rd_bank);
        end else begin
          r_rd_row <= r_rd_row + RW'(1);
        end
      end
    end
  end

  // Row storage carries no reset; stale rows are hidden by the valid/count masking below.
  always_ff @(posedge clk) begin
    if (w_wr_fire && !clear) r_mem[r_wr_bank][r_wr_row] <= write_data;
  end

  always_comb begin
    read_data_all = '0;
    read_data     = '0;
    read_last     = 1'b0;
    read_count    = '0;
    if (read_valid) begin
      read_count = w_head_count;
      if (READ_MODE == 0) begin
        for (int r = 0; r < DEPTH; r++) begin
          if (CW'(r) < w_head_count) read_data_all[r*ROW_W +: ROW_W] = r_mem[r_rd_bank][r];
        end
      end else begin
        read_data = r_mem[r_rd_bank][r_rd_row];
        read_last = w_rd_is_last;
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int b = 0; b < NUM_BANKS; b++) occupancy = occupancy + OW'(r_full[b]);
  end

endmodule

// File: tb/tb_tile_pingpong_buffer.sv
// Bench for tile_pingpong_buffer: one parallel-mode and one serial-mode instance,
// checked every cycle against a tile-queue model plus directed literal expectations.
module tb_tile_pingpong_buffer;
  localparam int NB = 2;
  localparam int D  = 4;
  localparam int W  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic clear;

  // parallel instance signals
  logic         p_wv, p_wl, p_rr;
  logic [W-1:0] p_wd;
  logic         p_wr_rdy, p_rv, p_last;
  logic [D*W-1:0] p_all;
  logic [W-1:0] p_d;
  logic [2:0]   p_cnt;
  logic [1:0]   p_occ;

  // serial instance signals
  logic         s_wv, s_wl, s_rr;
  logic [W-1:0] s_wd;
  logic         s_wr_rdy, s_rv, s_last;
  logic [D*W-1:0] s_all;
  logic [W-1:0] s_d;
  logic [2:0]   s_cnt;
  logic [1:0]   s_occ;

  tile_pingpong_buffer #(.NUM_BANKS(NB), .DEPTH(D), .ROW_W(W), .READ_MODE(0)) u_par (
    .clk(clk), .rst(rst), .clear(clear),
    .write_valid(p_wv), .write_ready(p_wr_rdy), .write_data(p_wd), .write_last(p_wl),
    .read_valid(p_rv), .read_ready(p_rr), .read_data_all(p_all), .read_data(p_d),
    .read_last(p_last), .read_count(p_cnt), .occupancy(p_occ)
  );

  tile_pingpong_buffer #(.NUM_BANKS(NB), .DEPTH(D), .ROW_W(W), .READ_MODE(1)) u_ser (
    .clk(clk), .rst(rst), .clear(clear),
    .write_valid(s_wv), .write_ready(s_wr_rdy), .write_data(s_wd), .write_last(s_wl),
    .read_valid(s_rv), .read_ready(s_rr), .read_data_all(s_all), .read_data(s_d),
    .read_last(s_last), .read_count(s_cnt), .occupancy(s_occ)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: row FIFO + FIFO of completed tile sizes ----------------
  // Index 0 models the parallel instance, index 1 the serial instance.
  logic [W-1:0] m_rows [2][16];
  int m_rh [2];
  int m_rn [2];
  int m_sz [2][8];
  int m_sh [2];
  int m_sn [2];
  int m_fill [2];
  int m_ri [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_rh[m] = 0; m_rn[m] = 0; m_sh[m] = 0; m_sn[m] = 0; m_fill[m] = 0; m_ri[m] = 0;
    end
  endtask

  task automatic model_step(input int m, input logic wv, input logic [W-1:0] wd,
                            input logic wl, input logic rr);
    bit rv;
    bit wr;
    int c;
    rv = m_sn[m] > 0;
    wr = m_sn[m] < NB;
    c  = rv ? m_sz[m][m_sh[m]] : 0;
    if (rr && rv) begin
      if (m == 0 || m_ri[m] == c - 1) begin
        m_rh[m] = (m_rh[m] + c) % 16;
        m_rn[m] = m_rn[m] - c;
        m_sh[m] = (m_sh[m] + 1) % 8;
        m_sn[m] = m_sn[m] - 1;
        m_ri[m] = 0;
      end else begin
        m_ri[m] = m_ri[m] + 1;
      end
    end
    if (wv && wr) begin
      m_rows[m][(m_rh[m] + m_rn[m]) % 16] = wd;
      m_rn[m]   = m_rn[m] + 1;
      m_fill[m] = m_fill[m] + 1;
      if (m_fill[m] == D || wl) begin
        m_sz[m][(m_sh[m] + m_sn[m]) % 8] = m_fill[m];
        m_sn[m]   = m_sn[m] + 1;
        m_fill[m] = 0;
      end
    end
  endtask

  always @(negedge rst) model_reset();

  always @(posedge clk) begin
    if (!rst || clear) begin
      model_reset();
    end else begin
      model_step(0, p_wv, p_wd, p_wl, p_rr);
      model_step(1, s_wv, s_wd, s_wl, s_rr);
    end
  end

  task automatic cmp(input int m, input logic wr, input logic rv, input logic [2:0] cnt,
                     input logic [1:0] occ, input logic [D*W-1:0] all,
                     input logic [W-1:0] d, input logic lst);
    string pre;
    bit e_rv;
    int c;
    logic [D*W-1:0] e_all;
    logic [W-1:0] e_d;
    bit e_lst;
    pre   = (m == 0) ? "p_" : "s_";
    e_rv  = m_sn[m] > 0;
    c     = e_rv ? m_sz[m][m_sh[m]] : 0;
    e_all = '0;
    e_d   = '0;
    e_lst = 1'b0;
    if (m == 0) begin
      for (int r = 0; r < D; r++)
        if (r < c) e_all[r*W +: W] = m_rows[m][(m_rh[m] + r) % 16];
    end else if (e_rv) begin
      e_d   = m_rows[m][(m_rh[m] + m_ri[m]) % 16];
      e_lst = (m_ri[m] == c - 1);
    end
    chk({pre, "wr_rdy"}, 64'(wr), 64'(m_sn[m] < NB));
    chk({pre, "rv"}, 64'(rv), 64'(e_rv));
    chk({pre, "cnt"}, 64'(cnt), 64'(c));
    chk({pre, "occ"}, 64'(occ), 64'(m_sn[m]));
    chk({pre, "all"}, 64'(all), 64'(e_all));
    chk({pre, "data"}, 64'(d), 64'(e_d));
    chk({pre, "last"}, 64'(lst), 64'(e_lst));
  endtask

  always @(negedge clk) begin
    cmp(0, p_wr_rdy, p_rv, p_cnt, p_occ, p_all, p_d, p_last);
    cmp(1, s_wr_rdy, s_rv, s_cnt, s_occ, s_all, s_d, s_last);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pw(input logic [W-1:0] d, input logic l);
    p_wv = 1'b1; p_wd = d; p_wl = l;
    tick();
    p_wv = 1'b0; p_wl = 1'b0;
  endtask

  task automatic sw(input logic [W-1:0] d, input logic l);
    s_wv = 1'b1; s_wd = d; s_wl = l;
    tick();
    s_wv = 1'b0; s_wl = 1'b0;
  endtask

  task automatic p_read();
    p_rr = 1'b1;
    tick();
    p_rr = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [W-1:0] exp_rows [4];

  initial begin
    rst = 1'b0; clear = 1'b0;
    p_wv = 0; p_wl = 0; p_rr = 0; p_wd = '0;
    s_wv = 0; s_wl = 0; s_rr = 0; s_wd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    // 1. reset values, then asynchronous reset in the middle of a fill
    chk("t1_wr_rdy", 64'(p_wr_rdy), 64'd1);
    chk("t1_rv", 64'(p_rv), 64'd0);
    chk("t1_occ", 64'(p_occ), 64'd0);
    chk("t1_all", 64'(p_all), 64'd0);
    pw(8'h5A, 1'b0);
    pw(8'h5B, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("t1_rst_wr_rdy", 64'(p_wr_rdy), 64'd1);
    chk("t1_rst_rv", 64'(p_rv), 64'd0);
    chk("t1_rst_occ", 64'(p_occ), 64'd0);
    chk("t1_rst_all", 64'(p_all), 64'd0);
    chk("t1_rst_cnt", 64'(p_cnt), 64'd0);
    chk("t1_rst_s_last", 64'(s_last), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // 2. parallel fill and single-handshake drain
    pw(8'h11, 1'b0); pw(8'h22, 1'b0); pw(8'h33, 1'b0); pw(8'h44, 1'b0);
    #2;
    chk("t2_rv", 64'(p_rv), 64'd1);
    chk("t2_all", 64'(p_all), 64'h44332211);
    chk("t2_cnt", 64'(p_cnt), 64'd4);
    chk("t2_occ", 64'(p_occ), 64'd1);
    p_read();
    #2;
    chk("t2_rv_after", 64'(p_rv), 64'd0);
    chk("t2_occ_after", 64'(p_occ), 64'd0);

    // 3. backpressure: both banks full, a ninth row is held until a bank frees
    do_clear();
    for (int i = 1; i <= 8; i++) pw(8'(i), 1'b0);
    #2;
    chk("t3_wr_rdy_full", 64'(p_wr_rdy), 64'd0);
    chk("t3_occ_full", 64'(p_occ), 64'd2);
    p_wv = 1'b1; p_wd = 8'h09;
    tick(); tick();
    #2;
    chk("t3_held_occ", 64'(p_occ), 64'd2);
    chk("t3_held_wr_rdy", 64'(p_wr_rdy), 64'd0);
    p_read();
    #2;
    chk("t3_free_occ", 64'(p_occ), 64'd1);
    chk("t3_free_wr_rdy", 64'(p_wr_rdy), 64'd1);
    tick();
    p_wv = 1'b0;
    #2;
    chk("t3_head_all", 64'(p_all), 64'h08070605);
    p_read();
    pw(8'h0A, 1'b0); pw(8'h0B, 1'b0); pw(8'h0C, 1'b0);
    #2;
    chk("t3_ninth_all", 64'(p_all), 64'h0C0B0A09);
    chk("t3_ninth_cnt", 64'(p_cnt), 64'd4);
    p_read();

    // 4. partial tile closed by write_last; stale rows above the count stay hidden
    do_clear();
    pw(8'hAA, 1'b0);
    pw(8'hBB, 1'b1);
    #2;
    chk("t4_cnt", 64'(p_cnt), 64'd2);
    chk("t4_all", 64'(p_all), 64'h0000BBAA);
    chk("t4_occ", 64'(p_occ), 64'd1);
    pw(8'hCC, 1'b1);
    #2;
    chk("t4_occ2", 64'(p_occ), 64'd2);
    p_read();
    #2;
    chk("t4_next_cnt", 64'(p_cnt), 64'd1);
    chk("t4_next_all", 64'(p_all), 64'h000000CC);
    p_read();

    // 5. serial mode with read_ready held high
    do_clear();
    s_rr = 1'b1;
    sw(8'h01, 1'b0); sw(8'h02, 1'b0); sw(8'h03, 1'b0); sw(8'h04, 1'b0);
    exp_rows[0] = 8'h01; exp_rows[1] = 8'h02; exp_rows[2] = 8'h03; exp_rows[3] = 8'h04;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk("t5_data", 64'(s_d), 64'(exp_rows[k]));
      chk("t5_last", 64'(s_last), 64'(k == 3));
      chk("t5_rv", 64'(s_rv), 64'd1);
      tick();
      #2;
    end
    chk("t5_rv_end", 64'(s_rv), 64'd0);
    sw(8'h01, 1'b0); sw(8'h02, 1'b0); sw(8'h03, 1'b1);
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("t5p_data", 64'(s_d), 64'(exp_rows[k]));
      chk("t5p_last", 64'(s_last), 64'(k == 2));
      tick();
      #2;
    end
    chk("t5p_rv_end", 64'(s_rv), 64'd0);
    s_rr = 1'b0;

    // 6. fill-complete and free in the same cycle, then clear over pending handshakes
    do_clear();
    pw(8'h01, 1'b0); pw(8'h02, 1'b0); pw(8'h03, 1'b0); pw(8'h04, 1'b0);
    pw(8'h05, 1'b0); pw(8'h06, 1'b0); pw(8'h07, 1'b0);
    p_wv = 1'b1; p_wd = 8'h08; p_rr = 1'b1;
    tick();
    p_wv = 1'b0; p_rr = 1'b0;
    #2;
    chk("t6_occ_same", 64'(p_occ), 64'd1);
    chk("t6_rv", 64'(p_rv), 64'd1);
    chk("t6_all", 64'(p_all), 64'h08070605);
    pw(8'h09, 1'b0); pw(8'h0A, 1'b0); pw(8'h0B, 1'b0); pw(8'h0C, 1'b0);
    #2;
    chk("t6_occ_full", 64'(p_occ), 64'd2);
    clear = 1'b1; p_wv = 1'b1; p_wd = 8'hEE; p_rr = 1'b1; s_wv = 1'b1; s_wd = 8'hEE;
    tick();
    clear = 1'b0; p_wv = 1'b0; p_rr = 1'b0; s_wv = 1'b0;
    #2;
    chk("t6_clr_occ", 64'(p_occ), 64'd0);
    chk("t6_clr_wr_rdy", 64'(p_wr_rdy), 64'd1);
    chk("t6_clr_rv", 64'(p_rv), 64'd0);
    chk("t6_clr_s_occ", 64'(s_occ), 64'd0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
